// File: rtl/v_tx_pkg.sv
// Shared types and helpers for the change-detecting TX chunk multiplexer.
// Holds FSM encoding, default chunk type base and flattened-bus slice helpers.
package v_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_CHUNK_TYPE_BASE = 5;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int bytes_lsb(input int idx, input int chunk_bytes);
        return idx * chunk_bytes * 8;
    endfunction

    function automatic int size_lsb(input int idx, input int index_size);
        return idx * index_size;
    endfunction

    // Chunk type wraps modulo 256 by truncation.
    function automatic logic [7:0] chunk_type(input int base, input int idx);
        return 8'(base + idx);
    endfunction

endpackage

// File: rtl/v_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index strictly above last_ptr, wrapping.
// Latency: combinational. Backpressure: grant only presented while advance is high.
// Pointer storage lives with the caller, which updates it from grant_idx.
module v_rr_arbiter
    import v_tx_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    input  logic [ptr_width(N)-1:0]   last_ptr,
    input  logic                      advance,
    output logic [N-1:0]              grant,
    output logic [ptr_width(N)-1:0]   grant_idx,
    output logic                      grant_vld
);

    localparam int PW = ptr_width(N);

    logic [N-1:0] sel;
    logic         found;

    always_comb begin
        sel       = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (((int'(last_ptr) + k) % N) == j)) begin
                    found     = 1'b1;
                    sel[j]    = 1'b1;
                    grant_idx = PW'(j);
                end
            end
        end
    end

    assign grant_vld = found && advance;
    assign grant     = advance ? sel : '0;

endmodule

// File: rtl/v_tx_chunk_mux.sv
// Multi-channel change-detecting TX chunk source; optional force_all resync under V_TX_CHUNK_MUX_FORCE_EN.
// Latency: live change -> pending after 1 edge -> offer after 2 edges; GAP of MIN_GAP_CYCLES+1 cycles after ack.
// Backpressure: offer holds stable until tx_ack; changes meanwhile coalesce into the newest value.
module v_tx_chunk_mux
    import v_tx_pkg::*;
#(
    parameter int CHANNEL_COUNT    = 4,
    parameter int CHUNK_BYTE_SIZE  = 32,
    parameter int CHUNK_INDEX_SIZE = 8,
    parameter int CHUNK_TYPE_BASE  = DEFAULT_CHUNK_TYPE_BASE,
    parameter int MIN_GAP_CYCLES   = 0
) (
    input  logic                                         CLK,
    input  logic                                         RST_N,
    input  logic [CHANNEL_COUNT*CHUNK_BYTE_SIZE*8-1:0]   ch_bytes,
    input  logic [CHANNEL_COUNT*CHUNK_INDEX_SIZE-1:0]    ch_size,
    input  logic [CHANNEL_COUNT-1:0]                     ch_enable,
    output logic                                         should_update,
    output logic [7:0]                                   tx_chunk_type,
    output logic [CHUNK_INDEX_SIZE-1:0]                  tx_chunk_size,
    output logic [CHUNK_BYTE_SIZE*8-1:0]                 tx_chunk_bytes,
`ifdef V_TX_CHUNK_MUX_FORCE_EN
    input  logic                                         force_all,
`endif
    input  logic                                         tx_ack,
    output logic [CHANNEL_COUNT-1:0]                     pending
);

    localparam int CH = CHANNEL_COUNT;
    localparam int BW = CHUNK_BYTE_SIZE * 8;
    localparam int IW = CHUNK_INDEX_SIZE;
    localparam int PW = ptr_width(CH);
    localparam int GW = (MIN_GAP_CYCLES > 0) ? $clog2(MIN_GAP_CYCLES + 1) : 1;
    localparam logic [IW-1:0] MAX_SIZE = IW'(CHUNK_BYTE_SIZE);

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   grant_idx;
    logic [CH-1:0]   grant;
    logic            grant_vld;
    logic            load;
    logic [CH-1:0]   dirty_d;
    logic [CH-1:0]   force_vec;

    logic [BW-1:0]   live_bytes     [CH];
    logic [IW-1:0]   live_size      [CH];
    logic [BW-1:0]   shadow_bytes_q [CH];
    logic [IW-1:0]   shadow_size_q  [CH];

    // Sizes are clamped before comparison so an over-range size settles after one send.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [IW-1:0] raw_size;
        assign live_bytes[i] = ch_bytes[bytes_lsb(i, CHUNK_BYTE_SIZE) +: BW];
        assign raw_size      = ch_size[size_lsb(i, IW) +: IW];
        assign live_size[i]  = (raw_size > MAX_SIZE) ? MAX_SIZE : raw_size;
        assign dirty_d[i]    = ch_enable[i] &&
                               (force_vec[i] ||
                                (live_bytes[i] != shadow_bytes_q[i]) ||
                                (live_size[i]  != shadow_size_q[i]));
    end

`ifdef V_TX_CHUNK_MUX_FORCE_EN
    logic [CH-1:0] force_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            force_q <= '0;
        end else begin
            force_q <= (force_q & ~(load ? grant : '0)) | (force_all ? ch_enable : '0);
        end
    end

    assign force_vec = force_q;
`else
    assign force_vec = '0;
`endif

    v_rr_arbiter #(
        .N (CH)
    ) u_arb (
        .req       (pending),
        .last_ptr  (rr_ptr_q),
        .advance   (state_q == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (tx_ack) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(MIN_GAP_CYCLES)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign should_update = (state_q == OFFER);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_cnt_q <= '0;
        end else if (state_q != GAP) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending  <= '0;
            rr_ptr_q <= PW'(CH - 1);
        end else begin
            pending <= dirty_d;
            if (load) begin
                rr_ptr_q <= grant_idx;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CH; i++) begin
                shadow_bytes_q[i] <= '0;
                shadow_size_q[i]  <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < CH; i++) begin
                if (grant[i]) begin
                    shadow_bytes_q[i] <= live_bytes[i];
                    shadow_size_q[i]  <= live_size[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_chunk_type  <= chunk_type(CHUNK_TYPE_BASE, 0);
            tx_chunk_size  <= '0;
            tx_chunk_bytes <= '0;
        end else if (load) begin
            tx_chunk_type  <= chunk_type(CHUNK_TYPE_BASE, int'(grant_idx));
            tx_chunk_size  <= live_size[grant_idx];
            tx_chunk_bytes <= live_bytes[grant_idx];
        end
    end

endmodule

// File: tb/tb_v_tx_chunk_mux.sv
// Scoreboard bench for v_tx_chunk_mux: 4 channels, 32-byte chunks, type base 5, holdoff 3.
module tb_v_tx_chunk_mux;

    logic           CLK;
    logic           RST_N;
    logic [1023:0]  ch_bytes;
    logic [31:0]    ch_size;
    logic [3:0]     ch_enable;
    logic           should_update;
    logic [7:0]     tx_chunk_type;
    logic [7:0]     tx_chunk_size;
    logic [255:0]   tx_chunk_bytes;
    logic           tx_ack;
    logic [3:0]     pending;
`ifdef V_TX_CHUNK_MUX_FORCE_EN
    logic           force_all;
`endif

    typedef struct packed {
        logic [7:0]   typ;
        logic [7:0]   size;
        logic [255:0] bytes;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    v_tx_chunk_mux #(
        .CHANNEL_COUNT    (4),
        .CHUNK_BYTE_SIZE  (32),
        .CHUNK_INDEX_SIZE (8),
        .CHUNK_TYPE_BASE  (5),
        .MIN_GAP_CYCLES   (3)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .ch_bytes       (ch_bytes),
        .ch_size        (ch_size),
        .ch_enable      (ch_enable),
        .should_update  (should_update),
        .tx_chunk_type  (tx_chunk_type),
        .tx_chunk_size  (tx_chunk_size),
        .tx_chunk_bytes (tx_chunk_bytes),
`ifdef V_TX_CHUNK_MUX_FORCE_EN
        .force_all      (force_all),
`endif
        .tx_ack         (tx_ack),
        .pending        (pending)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [255:0] d, input logic [7:0] s);
        ch_bytes[i*256 +: 256] = d;
        ch_size[i*8 +: 8]      = s;
    endtask

    task automatic push_exp(input logic [7:0] t, input logic [7:0] s, input logic [255:0] d);
        exp_t e;
        e.typ   = t;
        e.size  = s;
        e.bytes = d;
        exp_q.push_back(e);
    endtask

    // Returns at a negedge with should_update high, or after the budget expires.
    task automatic wait_offer(input string name, output int lat);
        lat = 0;
        forever begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            if (should_update) break;
            if (lat >= 60) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: no offer within %0d cycles", name, lat);
                break;
            end
        end
    endtask

    task automatic ack_now();
        tx_ack = 1'b1;
        @(posedge CLK);
        #1;
        tx_ack = 1'b0;
        @(negedge CLK);
        chk("drop_after_ack", should_update, 1'b0);
    endtask

    task automatic idle_check(input string name, input int cycles, input logic [3:0] exp_pend);
        repeat (cycles) @(negedge CLK);
        chk({name, "_no_offer"}, should_update, 1'b0);
        chk({name, "_pending"}, pending, exp_pend);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Monitor: compares each new offer against the head of the scoreboard.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge CLK);
            if (should_update && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_offer: type %0d size %0d, none expected", tx_chunk_type, tx_chunk_size);
                end else begin
                    e = exp_q.pop_front();
                    chk("offer_type", tx_chunk_type, e.typ);
                    chk("offer_size", tx_chunk_size, e.size);
                    chk("offer_bytes", tx_chunk_bytes, e.bytes);
                end
            end
            if (!should_update) seen = 1'b0;
        end
    end

    initial begin
        int lat;
        RST_N     = 1'b0;
        tx_ack    = 1'b0;
        ch_bytes  = '0;
        ch_size   = '0;
        ch_enable = 4'b1111;
`ifdef V_TX_CHUNK_MUX_FORCE_EN
        force_all = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_should_update", should_update, 1'b0);
        chk("rst_type", tx_chunk_type, 8'd5);
        chk("rst_size", tx_chunk_size, 8'd0);
        chk("rst_bytes", tx_chunk_bytes, 256'd0);
        chk("rst_pending", pending, 4'b0000);
        RST_N = 1'b1;

        // Single change on ch0: pending after one edge, offer after two.
        @(posedge CLK);
        #1;
        push_exp(8'd5, 8'd2, 256'h4849);
        set_ch(0, 256'h4849, 8'd2);
        @(negedge CLK);
        chk("t1_pending_before_edge", pending, 4'b0000);
        @(negedge CLK);
        chk("t1_pending_after_edge", pending, 4'b0001);
        chk("t1_no_offer_yet", should_update, 1'b0);
        wait_offer("t1_offer", lat);
        chk("t1_offer_second_edge", lat, 1);
        ack_now();
        idle_check("t1", 12, 4'b0000);

        // ch1 and ch3 together: round-robin order, holdoff of 3 extra cycles.
        @(posedge CLK);
        #1;
        push_exp(8'd6, 8'd4, 256'hA1A1);
        push_exp(8'd8, 8'd3, 256'h434833);
        set_ch(1, 256'hA1A1, 8'd4);
        set_ch(3, 256'h434833, 8'd3);
        wait_offer("t2_offer_ch1", lat);
        chk("t2_latency", lat, 2);
        ack_now();
        wait_offer("t2_offer_ch3", lat);
        chk("t2_gap_holdoff", lat, 5);
        ack_now();
        idle_check("t2", 12, 4'b0000);

        // ch2 bursts five values while ch0 is held in OFFER for 20 cycles.
        @(posedge CLK);
        #1;
        push_exp(8'd5, 8'd6, 256'h0C0FFEE);
        set_ch(0, 256'h0C0FFEE, 8'd6);
        wait_offer("t3_offer_ch0", lat);
        for (int j = 1; j <= 5; j++) begin
            @(posedge CLK);
            #1;
            set_ch(2, 256'h1000 + 256'(j), 8'(j));
        end
        push_exp(8'd7, 8'd5, 256'h1005);
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        chk("t3_offer_held", should_update, 1'b1);
        chk("t3_type_stable", tx_chunk_type, 8'd5);
        chk("t3_bytes_stable", tx_chunk_bytes, 256'h0C0FFEE);
        chk("t3_ch2_pending", pending, 4'b0100);
        ack_now();
        wait_offer("t3_offer_ch2", lat);
        ack_now();
        idle_check("t3", 15, 4'b0000);

        // Over-range size on ch0 is clamped and does not repeat.
        @(posedge CLK);
        #1;
        push_exp(8'd5, 8'd32, 256'h424947);
        set_ch(0, 256'h424947, 8'd40);
        wait_offer("t4_offer", lat);
        chk("t4_clamped_size", tx_chunk_size, 8'd32);
        ack_now();
        idle_check("t4", 15, 4'b0000);

        // Reset in the middle of an offer, then every non-zero channel is resent.
        @(posedge CLK);
        #1;
        push_exp(8'd6, 8'd2, 256'hB0B);
        set_ch(1, 256'hB0B, 8'd2);
        wait_offer("t5_offer", lat);
        RST_N = 1'b0;
        #1;
        chk("t5_rst_should_update", should_update, 1'b0);
        chk("t5_rst_type", tx_chunk_type, 8'd5);
        chk("t5_rst_size", tx_chunk_size, 8'd0);
        chk("t5_rst_bytes", tx_chunk_bytes, 256'd0);
        chk("t5_rst_pending", pending, 4'b0000);
        repeat (2) @(negedge CLK);
        push_exp(8'd5, 8'd32, 256'h424947);
        push_exp(8'd6, 8'd2, 256'hB0B);
        push_exp(8'd7, 8'd5, 256'h1005);
        push_exp(8'd8, 8'd3, 256'h434833);
        RST_N = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_offer("t5_resend", lat);
            ack_now();
        end
        idle_check("t5", 15, 4'b0000);

`ifdef V_TX_CHUNK_MUX_FORCE_EN
        // A force_all pulse resends every enabled channel once.
        push_exp(8'd5, 8'd32, 256'h424947);
        push_exp(8'd6, 8'd2, 256'hB0B);
        push_exp(8'd7, 8'd5, 256'h1005);
        push_exp(8'd8, 8'd3, 256'h434833);
        @(posedge CLK);
        #1;
        force_all = 1'b1;
        @(posedge CLK);
        #1;
        force_all = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_offer("t6_force_resend", lat);
            ack_now();
        end
        idle_check("t6", 15, 4'b0000);
`endif

        // A disabled channel never becomes pending; ack while idle is ignored.
        @(posedge CLK);
        #1;
        ch_enable = 4'b1101;
        set_ch(1, 256'hDEAD, 8'd2);
        tx_ack = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        tx_ack = 1'b0;
        idle_check("t7", 10, 4'b0000);

        chk("end_queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
